spike_aer_tx: RTL and testbench

- Output-side counterpart of the synapse/neuron mapping control. That control fans inputs out to synapses; this block collects per-timestep neuron spike vectors and sends them off-array.
- It serialises each spike frame into address-event (AER) packets over a valid/ready stream.
- Each packet carries the neuron index, a timestamp and a last-of-frame flag.
- It sits between the neuron array outputs and the off-array event link.

---
 rtl/spike_aer_tx.sv | 164 ++++++++++++++++
 tb/tb_spike_aer_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_aer_tx.sv
// spike_aer_tx: serialises per-timestep neuron spike frames into
// address-event (AER) packets on a valid/ready stream.
//
// Each accepted frame is masked to the active neurons (index <= num_neurons)
// and emitted as one packet per set bit, lowest neuron index first. Every
// packet carries the neuron index, the frame's timestamp and a last-of-frame
// flag. Frames offered while a previous frame is still being sent are
// dropped and recorded in the sticky ovf flag; the timestep counter still
// advances so the drop shows up as a gap in the timestamps.
//
// Optional feature (macro AER_EMPTY_FRAME_EN):
//   defined   - a frame with no active spikes emits one packet with
//               ev_empty=1, ev_last=1, ev_addr=0 and the frame timestamp.
//   undefined - empty frames emit nothing; ev_empty is tied to 0.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   num_neurons    highest active neuron index, sampled at frame capture
//   spike_vec      spike frame, bit i = neuron i fired
//   spike_valid    one pulse per timestep, qualifies spike_vec
//   spike_ready    high while a new frame can be captured
//   ev_valid/ev_ready  event stream handshake
//   ev_addr, ev_ts, ev_last, ev_empty  event packet fields (registered)
//   ovf, clr_ovf   sticky frame-dropped flag and its synchronous clear

module spike_aer_tx #(
  parameter int NUM_NEURONS = 4,
  parameter int TS_WIDTH    = 8,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          num_neurons,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic                   spike_valid,
  output logic                   spike_ready,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [AW-1:0]          ev_addr,
  output logic [TS_WIDTH-1:0]    ev_ts,
  output logic                   ev_last,
  output logic                   ev_empty,
  output logic                   ovf,
  input  logic                   clr_ovf
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                   state_reg;
  logic [NUM_NEURONS-1:0]   pending_reg;
  logic [TS_WIDTH-1:0]      ts_reg;
  logic                     ev_valid_reg;
  logic [AW-1:0]            ev_addr_reg;
  logic [TS_WIDTH-1:0]      ev_ts_reg;
  logic                     ev_last_reg;
  logic                     ovf_reg;

  logic [NUM_NEURONS-1:0]   mask;
  logic [NUM_NEURONS-1:0]   masked;
  logic [NUM_NEURONS-1:0]   pending_after;

  // Neuron i is active iff i <= num_neurons.
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_mask
    assign mask[gi] = (AW'(gi) <= num_neurons);
  end

  assign masked = spike_vec & mask;

  // Pending set once the currently presented event has been handed off.
  assign pending_after = pending_reg & ~(NUM_NEURONS'(1) << ev_addr_reg);

  // Index of the lowest set bit (0 when nothing is set).
  function automatic logic [AW-1:0] lowest_bit(input logic [NUM_NEURONS-1:0] v);
    lowest_bit = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = AW'(i);
    end
  endfunction

  // True when exactly one bit is set.
  function automatic logic one_hot(input logic [NUM_NEURONS-1:0] v);
    one_hot = (v != '0) && ((v & (v - NUM_NEURONS'(1))) == '0);
  endfunction

`ifdef AER_EMPTY_FRAME_EN
  logic ev_empty_reg;
  assign ev_empty = ev_empty_reg;
`else
  assign ev_empty = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      ts_reg       <= '0;
      ev_valid_reg <= 1'b0;
      ev_addr_reg  <= '0;
      ev_ts_reg    <= '0;
      ev_last_reg  <= 1'b0;
      ovf_reg      <= 1'b0;
`ifdef AER_EMPTY_FRAME_EN
      ev_empty_reg <= 1'b0;
`endif
    end else begin
      // Counter advances on every offered frame, accepted or not.
      if (spike_valid) ts_reg <= ts_reg + TS_WIDTH'(1);

      // A drop in the same cycle as a clear leaves the flag set.
      if (spike_valid && (state_reg != IDLE)) ovf_reg <= 1'b1;
      else if (clr_ovf)                       ovf_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (spike_valid) begin
            pending_reg <= masked;
            ev_ts_reg   <= ts_reg;
            if (masked != '0) begin
              state_reg    <= SEND;
              ev_valid_reg <= 1'b1;
              ev_addr_reg  <= lowest_bit(masked);
              ev_last_reg  <= one_hot(masked);
`ifdef AER_EMPTY_FRAME_EN
              ev_empty_reg <= 1'b0;
            end else begin
              state_reg    <= SEND;
              ev_valid_reg <= 1'b1;
              ev_addr_reg  <= '0;
              ev_last_reg  <= 1'b1;
              ev_empty_reg <= 1'b1;
`endif
            end
          end
        end
        SEND: begin
          // ev_valid is always high in SEND, so ev_ready alone is the handshake.
          if (ev_ready) begin
            pending_reg <= pending_after;
            if (ev_last_reg) begin
              state_reg    <= IDLE;
              ev_valid_reg <= 1'b0;
              ev_last_reg  <= 1'b0;
`ifdef AER_EMPTY_FRAME_EN
              ev_empty_reg <= 1'b0;
`endif
            end else begin
              ev_addr_reg <= lowest_bit(pending_after);
              ev_last_reg <= one_hot(pending_after);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spike_ready = (state_reg == IDLE);
  assign ev_valid    = ev_valid_reg;
  assign ev_addr     = ev_addr_reg;
  assign ev_ts       = ev_ts_reg;
  assign ev_last     = ev_last_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_spike_aer_tx.sv
module tb_spike_aer_tx;

  logic       clk;
  logic       rst;
  logic [1:0] num_neurons;
  logic [3:0] spike_vec;
  logic       spike_valid;
  logic       spike_ready;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_addr;
  logic [7:0] ev_ts;
  logic       ev_last;
  logic       ev_empty;
  logic       ovf;
  logic       clr_ovf;

  spike_aer_tx #(.NUM_NEURONS(4), .TS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .num_neurons(num_neurons), .spike_vec(spike_vec),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts), .ev_last(ev_last),
    .ev_empty(ev_empty), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] ts;
    logic       last;
    logic       empty;
  } pkt_t;

  pkt_t       sb[$];
  logic [7:0] ts_model;
  int         n_checks;
  int         n_pass;
  bit         rand_ready;
  bit         hold_v;
  logic [11:0] hold_pkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the frame's active spikes, lowest index first; an
  // empty frame yields a single marker packet only when the feature is built in.
  task automatic push_frame(input logic [3:0] vec, input int nn);
    int cnt;
    int k;
    pkt_t p;
    cnt = 0;
    for (int i = 0; i < 4; i++) if (i <= nn && vec[i]) cnt++;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (i <= nn && vec[i]) begin
        k++;
        p.addr = 2'(i); p.ts = ts_model; p.last = (k == cnt); p.empty = 1'b0;
        sb.push_back(p);
      end
    end
`ifdef AER_EMPTY_FRAME_EN
    if (cnt == 0) begin
      p.addr = 2'd0; p.ts = ts_model; p.last = 1'b1; p.empty = 1'b1;
      sb.push_back(p);
    end
`endif
  endtask

  // Waits for the block to accept, then offers one frame for one cycle.
  task automatic send_frame(input logic [3:0] vec, input int nn);
    int n;
    n = 0;
    while (!spike_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!spike_ready) begin
      n_checks++;
      $display("FAIL spike_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    num_neurons = 2'(nn);
    spike_vec   = vec;
    spike_valid = 1'b1;
    push_frame(vec, nn);
    ts_model++;
    @(posedge clk); #1;
    spike_valid = 1'b0;
  endtask

  // Offers a frame while the block is known to be busy: it must be dropped.
  task automatic drop_pulse(input logic clr);
    spike_vec   = 4'b1111;
    spike_valid = 1'b1;
    clr_ovf     = clr;
    ts_model++;
    @(posedge clk); #1;
    spike_valid = 1'b0;
    clr_ovf     = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && spike_ready) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", sb.size(), $time);
    end
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 ev_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops expected packets on handshakes and checks that a stalled
  // packet holds all its fields until accepted.
  always @(negedge clk) begin
    pkt_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(ev_valid), 32'd1);
        chk("hold_fields", 32'({ev_addr, ev_ts, ev_last, ev_empty}), 32'(hold_pkt));
      end
      if (ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got addr %0d ts %0d expected none at %0t", ev_addr, ev_ts, $time);
        end else begin
          e = sb.pop_front();
          chk("ev_addr", 32'(ev_addr), 32'(e.addr));
          chk("ev_ts", 32'(ev_ts), 32'(e.ts));
          chk("ev_last", 32'(ev_last), 32'(e.last));
          chk("ev_empty", 32'(ev_empty), 32'(e.empty));
        end
      end
      hold_v   = ev_valid && !ev_ready;
      hold_pkt = {ev_addr, ev_ts, ev_last, ev_empty};
    end
  end

  initial begin
    n_checks = 0; n_pass = 0; ts_model = 8'd0;
    rand_ready = 1'b0; hold_v = 1'b0; hold_pkt = '0;
    rst = 1'b1; num_neurons = 2'd3; spike_vec = 4'd0; spike_valid = 1'b0;
    ev_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    chk("rst_spike_ready", 32'(spike_ready), 32'd1);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_fields", 32'({ev_addr, ev_ts, ev_last, ev_empty}), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame: addr 0,1,3 back to back, ready returns after the last.
    ev_ready = 1'b1;
    send_frame(4'b1011, 3);
    chk("single_first_valid", 32'(ev_valid), 32'd1);
    chk("single_busy0", 32'(spike_ready), 32'd0);
    @(posedge clk); #1;
    chk("single_busy1", 32'(spike_ready), 32'd0);
    @(posedge clk); #1;
    chk("single_busy2", 32'(spike_ready), 32'd0);
    @(posedge clk); #1;
    chk("single_ready_back", 32'(spike_ready), 32'd1);
    wait_idle();

    // Masking, then a frame that masks to nothing.
    send_frame(4'b1110, 1);
    wait_idle();
    send_frame(4'b1100, 1);
`ifdef AER_EMPTY_FRAME_EN
    chk("empty_frame_valid", 32'(ev_valid), 32'd1);
`else
    chk("empty_frame_valid", 32'(ev_valid), 32'd0);
    chk("empty_frame_ready", 32'(spike_ready), 32'd1);
`endif
    wait_idle();

    // Backpressure: first event must sit stable for 5 cycles.
    ev_ready = 1'b0;
    send_frame(4'b0101, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(ev_valid), 32'd1);
      chk("bp_addr", 32'(ev_addr), 32'd0);
      @(posedge clk); #1;
    end
    ev_ready = 1'b1;
    wait_idle();

    // Overflow and timestamp gap.
    send_frame(4'b0011, 3);
    drop_pulse(1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    wait_idle();
    send_frame(4'b0011, 3);
    wait_idle();
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    send_frame(4'b0011, 3);
    drop_pulse(1'b1);
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    wait_idle();

    // Asynchronous reset after the first of three events.
    send_frame(4'b1011, 3);
    @(posedge clk); #1;
    ev_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ev_valid", 32'(ev_valid), 32'd0);
    chk("arst_spike_ready", 32'(spike_ready), 32'd1);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_pending_left", 32'(sb.size()), 32'd2);
    sb.delete();
    ts_model = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    ev_ready = 1'b1;
    send_frame(4'b0110, 3);
    wait_idle();

    // Randomised frames under random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    ev_ready = 1'b1;

    // Timestamp wrap: 256 frames then one more carrying ts 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ts_model = 8'd0;
    for (int f = 0; f < 257; f++) send_frame(4'b0001, 3);
    wait_idle();
    chk("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
